// File: rtl/register_file_32x32_pkg.sv
// Package: regfile_pkg
// Purpose: shared sizing constants for the 32x32 register file.
//   DEF_WIDTH  - default data width of each register
//   DEF_ADDR_W - default address width (depth = 2**DEF_ADDR_W)
//   NUM_REGS   - number of architectural registers
//   ZERO_REG   - index of the hardwired-zero register
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/register_file_32x32_register32.sv
// Module: register32
// Purpose: one WIDTH-bit storage register with write enable and an
//          asynchronous active-low clear.
// Ports:
//   clk   - clock, captures on rising edge
//   rst_n - asynchronous active-low clear (forces q to 0 immediately)
//   en    - write enable
//   d     - data to capture
//   q     - stored value
module register32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_32x32.sv
// Module: register_file_32x32
// Purpose: 32-entry register file with two combinational read ports, one
//          synchronous write port and register 0 hardwired to zero.
//          Optional same-cycle write-to-read bypass (BYPASS=1).
// Ports:
//   Clk           - clock; writes occur on the rising edge
//   ResetN        - asynchronous active-low clear of r1..r31
//   ReadData1     - contents of ReadRegister1
//   ReadData2     - contents of ReadRegister2
//   WriteData     - data written into WriteRegister
//   ReadRegister1 - read port 1 address
//   ReadRegister2 - read port 2 address
//   WriteRegister - write port address
//   RegWrite      - write enable, active high
module register_file_32x32
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic              Clk,
  input  logic              ResetN,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic              RegWrite
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:1] wr_en;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  // r0 has no storage; reading it always yields zero.
  assign regs[ZERO_REG] = '0;

  // Enable-gated one-hot decode: at most one wr_en bit is set, and address
  // 0 has no enable at all, so writes to r0 are discarded.
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    assign wr_en[i] = RegWrite && (WriteRegister == ADDR_W'(i));

    register32 #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (Clk),
      .rst_n(ResetN),
      .en   (wr_en[i]),
      .d    (WriteData),
      .q    (regs[i])
    );
  end

  // Two independent read muxes.
  always_comb begin
    stored1 = regs[ReadRegister1];
    stored2 = regs[ReadRegister2];
  end

  if (BYPASS != 0) begin : g_bypass
    logic hit1;
    logic hit2;

    // Forward the in-flight write only when it would actually be taken:
    // reset low or a target of r0 means the write is discarded.
    assign hit1 = ResetN && RegWrite && (WriteRegister == ReadRegister1) &&
                  (ReadRegister1 != ZERO_ADDR);
    assign hit2 = ResetN && RegWrite && (WriteRegister == ReadRegister2) &&
                  (ReadRegister2 != ZERO_ADDR);

    assign ReadData1 = hit1 ? WriteData : stored1;
    assign ReadData2 = hit2 ? WriteData : stored2;
  end else begin : g_no_bypass
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
  end

endmodule
